// File: rtl/prog_run_sequencer_pkg.sv
// Shared types and constants for the program run sequencer.
// Provides the FSM state encoding, the reset-sequence length and the default counter width.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } seq_state_t;

  localparam int SEQ_RST_CYCLES    = 2;
  localparam int SEQ_CYC_W_DEFAULT = 16;

  // Program-select width: enough bits for NUM_PROGS indices, never less than one.
  function automatic int ps_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_run_sequencer_if.sv
// Host/processor-facing signal bundle of the run sequencer.
// The slave modport is the sequencer itself; the master modport is the host/processor side.
interface prog_run_sequencer_if
  import seq_pkg::*;
#(
  parameter int NUM_PROGS = 3,
  parameter int CYC_W     = SEQ_CYC_W_DEFAULT
);

  localparam int PS_W = ps_width(NUM_PROGS);

  logic             Go;
  logic             DutAck;
  logic             DutReset;
  logic             DutStart;
  logic [PS_W-1:0]  ProgSel;
  logic             Busy;
  logic             Done;
  logic [CYC_W-1:0] CycleCount;
  logic             ResultValid;
  logic             TimedOut;

  modport master (
    output Go, DutAck,
    input  DutReset, DutStart, ProgSel, Busy, Done, CycleCount, ResultValid, TimedOut
  );

  modport slave (
    input  Go, DutAck,
    output DutReset, DutStart, ProgSel, Busy, Done, CycleCount, ResultValid, TimedOut
  );

endinterface

// File: rtl/prog_run_sequencer_run_timer.sv
// Saturating run-cycle counter with synchronous clear and enable.
// With SEQ_TIMEOUT_EN defined it also flags when the count equals TIMEOUT.
module run_timer #(
  parameter int CYC_W = 16
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16'hFFFF
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CYC_W-1:0] o_count
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic             o_timeout
`endif
);

  logic [CYC_W-1:0] r_count;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge Clk) begin
    if (Reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

`ifdef SEQ_TIMEOUT_EN
  assign o_timeout = (r_count == CYC_W'(TIMEOUT));
`endif

endmodule

// File: rtl/prog_run_sequencer.sv
// Batch run controller: resets, launches and times NUM_PROGS programs per Go request.
// Optional watchdog abort of hung programs is enabled by defining SEQ_TIMEOUT_EN.
module prog_run_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_PROGS = 3,
  parameter int CYC_W     = SEQ_CYC_W_DEFAULT,
  parameter int TIMEOUT   = 16'hFFFF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  prog_run_sequencer_if.slave   bus
);

  localparam int              PS_W      = ps_width(NUM_PROGS);
  localparam logic [PS_W-1:0] LAST_PROG = PS_W'(NUM_PROGS - 1);

  // Reject configurations where the counter could never reach the watchdog limit.
  if (NUM_PROGS < 1 || (TIMEOUT >> CYC_W) != 0) begin : g_bad_config
    $error("prog_run_sequencer: NUM_PROGS must be >= 1 and TIMEOUT must fit in CYC_W bits");
  end

  seq_state_t       r_state;
  logic             r_rst_cnt;
  logic [PS_W-1:0]  r_prog_sel;
  logic [CYC_W-1:0] r_cycle_count;

  logic             w_clear;
  logic             w_enable;
  logic [CYC_W-1:0] w_count;
  logic             w_fire;
  logic             w_go_accept;

  assign w_clear     = (r_state == S_LAUNCH);
  assign w_enable    = (r_state == S_RUN) && !bus.DutAck;
  assign w_go_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.Go;

`ifdef SEQ_TIMEOUT_EN
  logic w_timeout;
  logic r_timed_out;

  run_timer #(
    .CYC_W   (CYC_W),
    .TIMEOUT (TIMEOUT)
  ) u_run_timer (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_clear   (w_clear),
    .i_enable  (w_enable),
    .o_count   (w_count),
    .o_timeout (w_timeout)
  );

  // Ack on the same edge wins over the watchdog.
  assign w_fire = (r_state == S_RUN) && !bus.DutAck && w_timeout;

  always_ff @(posedge Clk) begin
    if (Reset || w_go_accept) begin
      r_timed_out <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (bus.DutAck) begin
        r_timed_out <= 1'b0;
      end else if (w_fire) begin
        r_timed_out <= 1'b1;
      end
    end
  end

  assign bus.TimedOut = r_timed_out;
`else
  run_timer #(
    .CYC_W (CYC_W)
  ) u_run_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_count  (w_count)
  );

  assign w_fire       = 1'b0;
  assign bus.TimedOut = 1'b0;
`endif

  // NOTE: Reset is synchronous here, so it sits inside the clocked branch and
  // is absent from the sensitivity list.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_rst_cnt     <= 1'b0;
      r_prog_sel    <= '0;
      r_cycle_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.Go) begin
            r_state    <= S_RST;
            r_rst_cnt  <= 1'b0;
            r_prog_sel <= '0;
          end
        end
        S_RST: begin
          if (r_rst_cnt == 1'(SEQ_RST_CYCLES - 1)) begin
            r_state <= S_LAUNCH;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        S_LAUNCH: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          // On a watchdog fire the counter already equals TIMEOUT.
          if (bus.DutAck || w_fire) begin
            r_cycle_count <= w_count;
            r_state       <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (r_prog_sel == LAST_PROG) begin
            r_state <= S_DONE;
          end else begin
            r_prog_sel <= r_prog_sel + 1'b1;
            r_rst_cnt  <= 1'b0;
            r_state    <= S_RST;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.DutReset    = (r_state == S_IDLE) || (r_state == S_RST);
  assign bus.DutStart    = (r_state == S_RST)  || (r_state == S_LAUNCH);
  assign bus.Busy        = (r_state == S_RST)  || (r_state == S_LAUNCH) ||
                           (r_state == S_RUN)  || (r_state == S_REPORT);
  assign bus.Done        = (r_state == S_DONE);
  assign bus.ResultValid = (r_state == S_REPORT);
  assign bus.ProgSel     = r_prog_sel;
  assign bus.CycleCount  = r_cycle_count;

endmodule

// File: doc/prog_run_sequencer.md
# prog_run_sequencer

Host-side run controller that sits directly upstream of the processor top level and owns its `Reset`, `Start` and `Ack` pins. On one `Go` request it runs a batch of `NUM_PROGS` programs back to back. For each program it:
- drives the processor reset/start sequence,
- selects the program index,
- counts execution cycles until the done flag,
- reports one result per program.

An optional watchdog aborts programs that never complete.

## Interface
Parameters:
- `NUM_PROGS`, default 3: programs per batch, minimum 1.
- `CYC_W`, default 16: cycle counter width.
- `TIMEOUT`, default 16'hFFFF: watchdog limit in RUN cycles. Must satisfy `TIMEOUT` ≤ 2^`CYC_W`-1.

Ports:
- `Clk` in 1: clock, posedge.
- `Reset` in 1: reset, synchronous, active-high.
- `Go` in 1: batch request; sampled only in IDLE or DONE.
- `DutAck` in 1: done flag from processor (level).
- `DutReset` out 1: processor reset.
- `DutStart` out 1: processor start.
- `ProgSel` out `PS_W`: current program index. `PS_W` = `$clog2(NUM_PROGS)`, minimum 1.
- `Busy` out 1: batch in progress.
- `Done` out 1: batch complete; holds until the next `Go`.
- `CycleCount` out `CYC_W`: cycle count of the most recently finished program.
- `ResultValid` out 1: one-cycle pulse; `CycleCount`, `ProgSel` and `TimedOut` are valid while it is high.
- `TimedOut` out 1: watchdog fired for the reported program.

## Operation
- FSM states: IDLE, RST, LAUNCH, RUN, REPORT, DONE.
- All outputs are decoded from or held in registers. There are no combinational paths from inputs to outputs.
- **IDLE**
  - `DutReset`=1, `DutStart`=0, `Busy`=0, `Done`=0.
  - `Go`=1 → RST; `ProgSel`←0; `TimedOut`←0.
- **RST**
  - Lasts exactly 2 cycles; a 1-bit sub-counter tracks them.
  - `DutReset`=1, `DutStart`=1, `Busy`=1.
  - → LAUNCH.
- **LAUNCH**
  - Lasts 1 cycle.
  - `DutReset`=0, `DutStart`=1.
  - Run counter ← 0.
  - → RUN.
- **RUN**
  - `DutReset`=0, `DutStart`=0.
  - At each edge where `DutAck`=0: run counter +1, saturating at all-ones.
  - At an edge where `DutAck`=1: `CycleCount`←counter, `TimedOut`←0, → REPORT.
  - `DutAck` is ignored in every state other than RUN. A stale `Ack` from the previous program has no effect.
- **REPORT**
  - Lasts 1 cycle with `ResultValid`=1.
  - If `ProgSel`==`NUM_PROGS`-1 → DONE.
  - Otherwise `ProgSel`+1 → RST.
  - `ProgSel` never wraps within a batch.
- **DONE**
  - `Done`=1, `Busy`=0, `DutReset`=0, `DutStart`=0.
  - `Go`=1 → RST; `ProgSel`←0; `Done`←0.
- `Go` while `Busy`=1 is ignored; it is not queued.
- Reset asserted mid-run (any state) → IDLE on the next edge. The in-flight result is discarded and no `ResultValid` is issued.
- Reset values:
  - State IDLE.
  - `DutReset`=1, `DutStart`=0, `ProgSel`=0, `Busy`=0, `Done`=0, `CycleCount`=0, `ResultValid`=0, `TimedOut`=0.

## Timing
- `Go` at edge N (state IDLE):
  - RST for edges N+1 to N+2.
  - LAUNCH at N+3.
  - RUN from N+4.
- `DutAck` is first sampled at the end of the first RUN cycle. `Ack` already high there yields `CycleCount`=0.
- `DutAck` rising after k low RUN cycles yields `CycleCount`=k. `ResultValid` is high in the cycle after that edge.
- Per-program overhead outside RUN: 4 cycles (RST 2, LAUNCH 1, REPORT 1).
- `Done` rises in the cycle after the last REPORT.

## Configuration
Macro: `SEQ_TIMEOUT_EN`.
- **Defined:**
  - In RUN, if counter==`TIMEOUT` and `DutAck`=0 at an edge: `CycleCount`←`TIMEOUT`, `TimedOut`←1, → REPORT.
  - The batch then continues with the next program.
  - `DutAck`=1 on the same edge takes priority: normal completion, `TimedOut`=0.
- **Undefined:**
  - No watchdog; RUN waits indefinitely and the counter saturates.
  - `TimedOut` is tied to 0 and the `TIMEOUT` parameter is unused.

## Structure
- Package `seq_pkg`:
  - FSM state enum `seq_state_t`.
  - Constant `SEQ_RST_CYCLES`=2.
  - Default for `CYC_W`.
- Sub-module `run_timer`:
  - Clear, enable and saturating increment.
  - Under `SEQ_TIMEOUT_EN`, a `TIMEOUT` compare output.
- The FSM, `ProgSel` and the result registers live in the top module.

## Test plan
- **Three-program batch.** Reset, then `Go` pulse; DUT model raises `Ack` after 10, 20 and 30 low RUN cycles. Expect:
  - three `ResultValid` pulses with `CycleCount` 10/20/30 and `ProgSel` 0/1/2;
  - `Done`=1 in the cycle after the third.
- **Stale Ack.** `DutAck` held at 1 through RST and LAUNCH, then 0 for 5 RUN cycles, then 1. Expect `CycleCount`=5.
- **Immediate Ack and ignored Go.** `Ack`=1 in the first RUN cycle gives `CycleCount`=0. `Go` pulsed during RUN is ignored: `ProgSel` sequence unchanged, with no extra batch.
- **Reset mid-RUN.** Assert `Reset` at RUN cycle 7 of program 1. Expect:
  - next cycle IDLE with `DutReset`=1, `ProgSel`=0, `Busy`=0;
  - no `ResultValid`.
- **Watchdog (`SEQ_TIMEOUT_EN`, `TIMEOUT`=50).** `Ack` never rises. Expect `CycleCount`=50, `TimedOut`=1, `ResultValid`, then RST for the next program. Without the macro, Busy stays 1 after 1000 cycles.
- **Restart from DONE.** `Go` in DONE. Expect `Done`←0, `ProgSel`=0, and the RST/LAUNCH sequence timing repeated exactly.
